// File: rtl/chan_debounce_pkg.sv
// Shared types and default constants for the chan_debounce_array slice.
package chan_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    PEND_HI,
    STABLE_HI,
    PEND_LO
  } deb_state_e;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_STABLE_CYC = 16;

endpackage

// File: rtl/chan_debounce_lane.sv
// Single-channel debounce filter: y follows a after STABLE_CYC stable enabled cycles.
// Optional rise/fall pulses are built when CHAN_DEBOUNCE_EDGE_EN is defined.
module chan_debounce_lane
  import chan_debounce_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int STABLE_CYC = DEF_STABLE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  output logic y,
  output logic chg
`ifdef CHAN_DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  if (STABLE_CYC < 1 || STABLE_CYC > (1 << CNT_W) - 1) begin : gen_bad_cfg
    $error("chan_debounce_lane: STABLE_CYC out of range for CNT_W");
  end

  // cnt is 0 in the STABLE_* states, so LAST==0 makes them toggle directly.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYC - 1);

  deb_state_e       state;
  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state uses <= only so every lane register samples pre-edge values;
  // the reset is synchronous, hence it sits inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE_LO;
      cnt   <= '0;
      y     <= 1'b0;
      chg   <= 1'b0;
`ifdef CHAN_DEBOUNCE_EDGE_EN
      rise  <= 1'b0;
      fall  <= 1'b0;
`endif
    end else begin
      chg  <= 1'b0;
`ifdef CHAN_DEBOUNCE_EDGE_EN
      rise <= 1'b0;
      fall <= 1'b0;
`endif
      if (en) begin
        unique case (state)
          STABLE_LO, PEND_HI: begin
            if (!a) begin
              state <= STABLE_LO;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= STABLE_HI;
              cnt   <= '0;
              y     <= 1'b1;
              chg   <= 1'b1;
`ifdef CHAN_DEBOUNCE_EDGE_EN
              rise  <= 1'b1;
`endif
            end else begin
              state <= PEND_HI;
              cnt   <= cnt + CNT_W'(1);
            end
          end
          STABLE_HI, PEND_LO: begin
            if (a) begin
              state <= STABLE_HI;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= STABLE_LO;
              cnt   <= '0;
              y     <= 1'b0;
              chg   <= 1'b1;
`ifdef CHAN_DEBOUNCE_EDGE_EN
              fall  <= 1'b1;
`endif
            end else begin
              state <= PEND_LO;
              cnt   <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= STABLE_LO;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/chan_debounce_array.sv
// N-channel debounce array: one chan_debounce_lane per channel in gen_lane[i].
// Define CHAN_DEBOUNCE_EDGE_EN to add the rise/fall pulse outputs.
module chan_debounce_array
  import chan_debounce_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int STABLE_CYC = DEF_STABLE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] a,
  output logic [NUM_CH-1:0] y,
  output logic [NUM_CH-1:0] chg
`ifdef CHAN_DEBOUNCE_EDGE_EN
  ,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
`endif
);

  if (NUM_CH < 1) begin : gen_bad_ch
    $error("chan_debounce_array: NUM_CH must be at least 1");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_lane
    chan_debounce_lane #(
      .CNT_W     (CNT_W),
      .STABLE_CYC(STABLE_CYC)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (a[i]),
      .y   (y[i]),
      .chg (chg[i])
`ifdef CHAN_DEBOUNCE_EDGE_EN
      ,
      .rise(rise[i]),
      .fall(fall[i])
`endif
    );
  end

endmodule

// File: tb/tb_chan_debounce_array.sv
// Directed bench for chan_debounce_array: a vector table plus hand-written corner sequences.
module tb_chan_debounce_array;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] a;
  logic [3:0] y;
  logic [3:0] chg;
  logic [3:0] a1;
  logic [3:0] y1;
  logic [3:0] chg1;
`ifdef CHAN_DEBOUNCE_EDGE_EN
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] rise1;
  logic [3:0] fall1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  chan_debounce_array #(.NUM_CH(4), .CNT_W(8), .STABLE_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .a   (a),
    .y   (y),
    .chg (chg)
`ifdef CHAN_DEBOUNCE_EDGE_EN
    ,
    .rise(rise),
    .fall(fall)
`endif
  );

  chan_debounce_array #(.NUM_CH(4), .CNT_W(8), .STABLE_CYC(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .a   (a1),
    .y   (y1),
    .chg (chg1)
`ifdef CHAN_DEBOUNCE_EDGE_EN
    ,
    .rise(rise1),
    .fall(fall1)
`endif
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] a;
    int         ncyc;
    logic [3:0] y;
    logic [3:0] chg;
  } vec_t;

  vec_t vt[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit after the last one for sampling.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int pulses;

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    a   = 4'h0;
    a1  = 4'h0;

    //            rst   en    a     n   y     chg
    vt[0]  = '{1'b1, 1'b1, 4'hF,  1, 4'h0, 4'h0};
    vt[1]  = '{1'b1, 1'b1, 4'hF,  1, 4'h0, 4'h0};
    vt[2]  = '{1'b1, 1'b1, 4'hF,  1, 4'h0, 4'h0};
    vt[3]  = '{1'b0, 1'b1, 4'hF, 15, 4'h0, 4'h0};
    vt[4]  = '{1'b0, 1'b1, 4'hF,  1, 4'hF, 4'hF};
    vt[5]  = '{1'b0, 1'b1, 4'hF,  1, 4'hF, 4'h0};
    vt[6]  = '{1'b0, 1'b1, 4'h0, 15, 4'hF, 4'h0};
    vt[7]  = '{1'b0, 1'b1, 4'h0,  1, 4'h0, 4'hF};
    vt[8]  = '{1'b0, 1'b1, 4'h0,  1, 4'h0, 4'h0};
    vt[9]  = '{1'b0, 1'b1, 4'h5, 15, 4'h0, 4'h0};
    vt[10] = '{1'b0, 1'b1, 4'h5,  1, 4'h5, 4'h5};
    vt[11] = '{1'b0, 1'b1, 4'hA,  1, 4'h5, 4'h0};
    vt[12] = '{1'b0, 1'b1, 4'hA, 14, 4'h5, 4'h0};
    vt[13] = '{1'b0, 1'b1, 4'hA,  1, 4'hA, 4'hF};
    vt[14] = '{1'b0, 1'b1, 4'h5,  8, 4'hA, 4'h0};
    vt[15] = '{1'b0, 1'b0, 4'h5, 10, 4'hA, 4'h0};
    vt[16] = '{1'b0, 1'b1, 4'h5,  7, 4'hA, 4'h0};
    vt[17] = '{1'b0, 1'b1, 4'h5,  1, 4'h5, 4'hF};
    vt[18] = '{1'b0, 1'b0, 4'h5,  3, 4'h5, 4'h0};

    for (int i = 0; i < 19; i++) begin
      rst = vt[i].rst;
      en  = vt[i].en;
      a   = vt[i].a;
      tick(vt[i].ncyc);
      check($sformatf("vec%0d y", i), 32'(y), 32'(vt[i].y));
      check($sformatf("vec%0d chg", i), 32'(chg), 32'(vt[i].chg));
    end

    // Single-lane rise: y[0] on the 16th edge, chg[0] for one cycle only.
    en  = 1'b1;
    rst = 1'b1;
    a   = 4'h0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("t2 reset y", 32'(y), 32'h0);
    a = 4'b0001;
    for (int k = 1; k <= 17; k++) begin
      tick(1);
      check($sformatf("t2 y edge%0d", k), 32'(y), (k >= 16) ? 32'h1 : 32'h0);
      check($sformatf("t2 chg edge%0d", k), 32'(chg), (k == 16) ? 32'h1 : 32'h0);
    end

    // Glitch: 15 high, 1 low, 16 high -> exactly one toggle on lane 1.
    pulses = 0;
    a = 4'b0011;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      pulses += int'(chg[1]);
    end
    a = 4'b0001;
    tick(1);
    pulses += int'(chg[1]);
    check("t3 y after glitch", 32'(y), 32'h1);
    a = 4'b0011;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      pulses += int'(chg[1]);
    end
    check("t3 y before final edge", 32'(y), 32'h1);
    tick(1);
    pulses += int'(chg[1]);
    check("t3 y after final edge", 32'(y), 32'h3);
    check("t3 chg at toggle", 32'(chg), 32'h2);
    check("t3 pulse count", 32'(pulses), 32'd1);

    // Freeze mid-count on lane 2: toggle arrives 5 cycles late, no chg while frozen.
    a = 4'b0111;
    tick(8);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check($sformatf("t4 chg frozen%0d", k), 32'(chg), 32'h0);
    end
    check("t4 y frozen", 32'(y), 32'h3);
    en = 1'b1;
    tick(7);
    check("t4 y before toggle", 32'(y), 32'h3);
    tick(1);
    check("t4 y after toggle", 32'(y), 32'h7);
    check("t4 chg at toggle", 32'(chg), 32'h4);

    // Reset mid-count discards pending counts and clears all levels.
    a = 4'b1010;
    tick(8);
    check("t5 y pending", 32'(y), 32'h7);
    rst = 1'b1;
    tick(1);
    check("t5 y in reset", 32'(y), 32'h0);
    check("t5 chg in reset", 32'(chg), 32'h0);
    rst = 1'b0;
    tick(15);
    check("t5 y restart 15", 32'(y), 32'h0);
    tick(1);
    check("t5 y restart 16", 32'(y), 32'hA);
    check("t5 chg restart 16", 32'(chg), 32'hA);

    // STABLE_CYC=1 instance: one-cycle pulse on lane 3 toggles up then down.
    check("t6 y1 idle", 32'(y1), 32'h0);
    a1 = 4'h8;
    tick(1);
    check("t6 y1 up", 32'(y1), 32'h8);
    check("t6 chg1 up", 32'(chg1), 32'h8);
`ifdef CHAN_DEBOUNCE_EDGE_EN
    check("t6 rise1 up", 32'(rise1), 32'h8);
    check("t6 fall1 up", 32'(fall1), 32'h0);
`endif
    a1 = 4'h0;
    tick(1);
    check("t6 y1 down", 32'(y1), 32'h0);
    check("t6 chg1 down", 32'(chg1), 32'h8);
`ifdef CHAN_DEBOUNCE_EDGE_EN
    check("t6 rise1 down", 32'(rise1), 32'h0);
    check("t6 fall1 down", 32'(fall1), 32'h8);
`endif
    tick(1);
    check("t6 chg1 idle", 32'(chg1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
